// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
package muldiv_pkg;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DZERO} state_t;
endpackage

// File: rtl/muldiv_datapath.sv
// Combinational single-iteration step (shift-add / restoring divide) and final sign fix.
module muldiv_datapath #(
  parameter int XLEN = 32
) (
  input  logic            i_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_d,
  input  logic            i_neg_a,
  input  logic            i_neg_b,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q,
  output logic [XLEN-1:0] o_fix_hi,
  output logic [XLEN-1:0] o_fix_lo
);
  logic [XLEN:0]     w_sum;
  logic [XLEN:0]     w_rem_s;
  logic [XLEN:0]     w_diff;
  logic [2*XLEN-1:0] w_prod;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_d} : '0);
    w_rem_s = {i_acc, i_q[XLEN-1]};
    w_diff  = w_rem_s - {1'b0, i_d};
    o_acc   = w_sum[XLEN:1];
    o_q     = {w_sum[0], i_q[XLEN-1:1]};
    if (i_div) begin
      // Remainder stays below the divisor, so the difference top bit is a clean sign.
      if (!w_diff[XLEN]) begin
        o_acc = w_diff[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_rem_s[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_comb begin
    w_prod = {i_acc, i_q};
    if (i_neg_a ^ i_neg_b) w_prod = -w_prod;
    if (i_div) begin
      o_fix_lo = (i_neg_a ^ i_neg_b) ? -i_q : i_q;
      o_fix_hi = i_neg_a ? -i_acc : i_acc;
    end else begin
      o_fix_hi = w_prod[2*XLEN-1:XLEN];
      o_fix_lo = w_prod[XLEN-1:0];
    end
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mult/div unit owning HI/LO; results land one cycle after FIX/DZERO with done.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc, r_q, r_d;
  logic             r_div, r_neg_a, r_neg_b;
  logic [XLEN-1:0]  r_res_hi, r_res_lo;
  logic             r_commit, r_done;
  logic [XLEN-1:0]  r_hi, r_lo;

  logic             w_accept, w_sgn, w_busy;
  logic [XLEN-1:0]  w_abs_rs, w_abs_rt;
  logic [XLEN-1:0]  w_step_acc, w_step_q, w_fix_hi, w_fix_lo;

  // The commit cycle still counts as busy so HI/LO consumers never see stale values.
  assign w_busy   = (r_state != IDLE) || r_commit;
  assign w_accept = start && !w_busy;
  assign w_sgn    = ~op[0];
  assign w_abs_rs = (w_sgn && rs_val[XLEN-1]) ? -rs_val : rs_val;
  assign w_abs_rt = (w_sgn && rt_val[XLEN-1]) ? -rt_val : rt_val;

  assign busy = w_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  muldiv_datapath #(.XLEN(XLEN)) u_dp (
    .i_div    (r_div),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_d      (r_d),
    .i_neg_a  (r_neg_a),
    .i_neg_b  (r_neg_b),
    .o_acc    (w_step_acc),
    .o_q      (w_step_q),
    .o_fix_hi (w_fix_hi),
    .o_fix_lo (w_fix_lo)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:       if (w_accept) w_state_nx = (op[1] && rt_val == '0) ? DZERO : RUN;
      RUN:        if (r_cnt == LAST) w_state_nx = FIX;
      FIX, DZERO: w_state_nx = IDLE;
      default:    w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_d      <= '0;
      r_div    <= 1'b0;
      r_neg_a  <= 1'b0;
      r_neg_b  <= 1'b0;
      r_res_hi <= '0;
      r_res_lo <= '0;
      r_commit <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done   <= r_commit;
      r_commit <= 1'b0;
      unique case (r_state)
        IDLE: if (w_accept) begin
          r_div   <= op[1];
          r_neg_a <= w_sgn & rs_val[XLEN-1];
          r_neg_b <= w_sgn & rt_val[XLEN-1];
          r_acc   <= '0;
          r_cnt   <= '0;
          // Dividend shifts out of the quotient slot; multiplier shifts out the same way.
          r_q     <= op[1] ? w_abs_rs : w_abs_rt;
          r_d     <= op[1] ? w_abs_rt : w_abs_rs;
        end
        RUN: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        FIX: begin
          r_res_hi <= w_fix_hi;
          r_res_lo <= w_fix_lo;
          r_commit <= 1'b1;
        end
        DZERO: begin
          r_res_hi <= r_neg_a ? -r_q : r_q;
          r_res_lo <= '1;
          r_commit <= 1'b1;
        end
        default: ;
      endcase
      if (r_commit) begin
        r_hi <= r_res_hi;
        r_lo <= r_res_lo;
      end else if (!w_busy) begin
        if (hi_we) r_hi <= wdata;
        if (lo_we) r_lo <= wdata;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random checks of muldiv_sequencer against a plain-arithmetic HI/LO model.
module tb_muldiv_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we, busy, done;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, wdata, hi, lo;
  int          n_chk = 0;
  int          n_fail = 0;

  muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    if (o == 2'b00) begin
      p = 64'(sa * sb); eh = p[63:32]; el = p[31:0];
    end else if (o == 2'b01) begin
      p = ua * ub; eh = p[63:32]; el = p[31:0];
    end else if (b == 0) begin
      eh = a; el = 32'hFFFF_FFFF;
    end else if (o == 2'b10) begin
      el = 32'(sa / sb); eh = 32'(sa % sb);
    end else begin
      el = a / b; eh = a % b;
    end
  endfunction

  // Issue one op and follow it to done. inj injects a start+mthi at cycle 10 of the op.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input bit b2b, input bit inj);
    logic [31:0] eh, el;
    int          n, lat;
    bit          busy_ok;
    model(o, a, b, eh, el);
    lat = (o[1] && b == 0) ? 2 : 34;
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
    n = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (inj && n == 10) begin
        start = 1'b1; hi_we = 1'b1; wdata = 32'hDEAD;
        op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      end else begin
        start = 1'b0; hi_we = 1'b0;
      end
      @(posedge clk); #1; n++;
    end
    start = 1'b0; hi_we = 1'b0;
    check({tag, "/latency"}, 64'(n), 64'(lat));
    check({tag, "/busy_while_running"}, 64'(busy_ok), 64'd1);
    check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
    check({tag, "/hi"}, 64'(hi), 64'(eh));
    check({tag, "/lo"}, 64'(lo), 64'(el));
    if (!b2b) begin
      @(posedge clk); #1;
      check({tag, "/done_single"}, 64'(done), 64'd0);
    end
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    int          seen;
    reset = 1'b1; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/done", 64'(done), 64'd0);
    check("rst/hi", 64'(hi), 64'd0);
    check("rst/lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, "mult_m3x5", 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_ff", 1'b0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mult_m1xm1", 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div_m7d2", 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, "divu_100d7", 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1", 1'b0, 1'b0);
    run_op(2'b10, 32'h0000_1234, 32'd0, "div_by_zero", 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, "div_neg_by_zero", 1'b0, 1'b0);
    run_op(2'b00, 32'd123456, 32'hFFFF_FF85, "mult_busy_prot", 1'b0, 1'b1);

    // back-to-back: second start lands in the done cycle of the first
    run_op(2'b01, 32'd1000, 32'd3000, "b2b_first", 1'b1, 1'b0);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd16, "b2b_second", 1'b0, 1'b0);

    // mthi/mtlo alongside an accepted start: result wins
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h5555_AAAA;
    run_op(2'b00, 32'd9, 32'd9, "start_with_mt", 1'b0, 1'b0);

    // reset mid-divu aborts with no done and clears HI/LO
    start = 1'b1; op = 2'b11; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("abort/busy", 64'(busy), 64'd0);
    check("abort/hi", 64'(hi), 64'd0);
    check("abort/lo", 64'(lo), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) seen++;
      @(posedge clk); #1;
    end
    check("abort/no_done", 64'(seen), 64'd0);
    run_op(2'b00, 32'd6, 32'd7, "mult_6x7", 1'b0, 1'b0);

    // mthi while idle, then mthi+mtlo together
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(posedge clk); #1; hi_we = 1'b0;
    check("mthi/hi", 64'(hi), 64'h0000_DEAD);
    check("mthi/lo_kept", 64'(lo), 64'd42);
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0BAD_F00D;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    check("mthilo/hi", 64'(hi), 64'h0BAD_F00D);
    check("mthilo/lo", 64'(lo), 64'h0BAD_F00D);

    for (int i = 0; i < 16; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) ra = 32'($signed($urandom_range(0, 40)) - 20);
      if ($urandom_range(0, 3) == 0) rb = 32'($signed($urandom_range(0, 40)) - 20);
      if ($urandom_range(0, 5) == 0) rb = 32'd0;
      run_op(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Iterative multi-cycle multiply/divide unit that owns the HI/LO register pair for the MIPS core.
- Decode issues mult/multu/div/divu through a start pulse.
- The block runs a shift-add multiply or a restoring divide over XLEN cycles and writes HI/LO.
- It holds busy high so the pipeline stalls any mfhi/mflo or new mult/div until done.
- It also services mthi/mtlo writes.

Parameters:
- XLEN, 32, operand width; HI and LO are XLEN each. The iteration count equals XLEN.
- CNT_W, 6, iteration counter width, ≥ clog2(XLEN)+1.

Ports:
- clk, input, 1, system clock, all state on rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request to begin an operation; sampled only when busy=0.
- op, input, 2, operation: 00 mult (signed), 01 multu, 10 div (signed), 11 divu.
- rs_val, input, XLEN, multiplicand or dividend.
- rt_val, input, XLEN, multiplier or divisor.
- hi_we, input, 1, mthi write strobe.
- lo_we, input, 1, mtlo write strobe.
- wdata, input, XLEN, data for mthi/mtlo.
- busy, output, 1, high while an operation is in flight; the pipeline stalls HI/LO consumers on busy.
- done, output, 1, one-cycle pulse in the first cycle the new HI/LO are visible.
- hi, output, XLEN, HI register: product upper half or remainder.
- lo, output, XLEN, LO register: product lower half or quotient.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal operand registers cleared.
- Reset mid-operation aborts the operation: no done pulse, HI/LO forced to 0.
- Reset has priority over every other input.

States:
- IDLE: busy=0. On start, latch op, sign flags and |rs_val|, |rt_val| (raw values for unsigned ops), clear the accumulator, counter=0.
  - Go to DZERO if op is div/divu and rt_val==0; otherwise go to RUN.
- RUN: busy=1. One iteration per cycle; counter increments.
  - Multiply: if multiplier LSB is set, add multiplicand into the upper half; then shift the {acc, multiplier} pair right 1.
  - Divide (restoring): shift {rem, quo} left 1; trial-subtract the divisor; keep the result and set the quotient bit if the difference is non-negative.
  - After iteration XLEN-1, go to FIX.
- FIX: busy=1.
  - Signed mult: negate the 2*XLEN product if the operand signs differ.
  - Signed div: negate the quotient if the signs differ; give the remainder the dividend's sign.
  - Write HI/LO, go to IDLE, set done=1 for the next cycle.
- DZERO: busy=1 for one cycle. Write hi=rs_val, lo=all-ones, go to IDLE, done=1 next cycle.

Timing:
- With start sampled at edge 0, busy=1 after edges 0..XLEN+1.
- New HI/LO and done=1 are visible after edge XLEN+2, i.e. 34 cycles for XLEN=32, with busy=0 in that cycle.
- Divide by zero: result visible after edge 2.
- Back-to-back: a start in the done cycle is accepted.
- start while busy=1 is ignored (not queued); op and operands are not re-sampled.

Arithmetic:
- Signed division truncates toward zero. div of 0x80000000 by 0xFFFFFFFF gives lo=0x80000000, hi=0.
- No overflow or exception flags.

mthi/mtlo:
- Applied at the edge only when busy=0; ignored while busy=1.
- If asserted together with an accepted start, the write is applied and the later result overwrites it.
- hi_we and lo_we may assert together.

Outputs:
- hi/lo hold their value between writes; they are never partial while busy.
- done is registered and glitch-free.

Decomposition:
- Package muldiv_pkg holds the op encodings (OP_MULT, OP_MULTU, OP_DIV, OP_DIVU) and the state enum (IDLE, RUN, FIX, DZERO).
- One natural sub-module, muldiv_datapath, holds the combinational iteration step and the sign-fix logic. The sequencer owns the FSM, counter and HI/LO registers.

Test Plan:
- mult: rs=-3 (0xFFFFFFFD), rt=5 → after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFF1, done pulses once, busy low that cycle.
- multu: rs=rt=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Signed mult of the same operands → hi=0, lo=1.
- div -7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100/7 → lo=0x0000000E, hi=0x00000002. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- div by zero: rs=0x1234, rt=0 → after 2 cycles hi=0x1234, lo=0xFFFFFFFF, done=1.
- Busy protection: start with new operands, plus hi_we/wdata=0xDEAD, at cycle 10 of a mult → ignored; the original result is delivered. mthi 0xDEAD while idle → hi=0xDEAD next cycle, lo unchanged.
- reset at cycle 15 of a divu → next cycle busy=0, hi=lo=0, no done pulse. A subsequent mult 6*7 → lo=42, hi=0.
